mem_ctrl: RTL and testbench

Memory controller between the pipeline and the byte-wide unified RAM. It accepts word, halfword and byte load/store requests from the MEM stage and 32-bit instruction fetches from the IF stage. Each request is serialised into one RAM byte access per cycle, and little-endian results are returned with a one-cycle completion pulse. MEM requests have priority over IF. Sign extension is done by the MEM stage, not here.

---
 rtl/mem_ctrl_pkg.sv | 28 ++
 rtl/mem_ctrl.sv | 176 +++++++++++++++++
 tb/tb_mem_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared widths, cnf codes and controller state encoding for mem_ctrl.
package mem_ctrl_pkg;

  localparam int unsigned MemAddrW = 32;
  localparam int unsigned MemDataW = 32;
  localparam int unsigned InstW    = 32;
  localparam int unsigned RegAddrW = 5;

  localparam logic [1:0] CnfNone = 2'd0;
  localparam logic [1:0] CnfB    = 2'd1;
  localparam logic [1:0] CnfH    = 2'd2;
  localparam logic [1:0] CnfW    = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StMrd,
    StMwr,
    StIrd,
    StMdone,
    StIdone
  } state_e;

  // Index of the final byte of an access; the W code means four bytes, not three.
  function automatic logic [1:0] last_idx(input logic [1:0] cnf);
    return (cnf == CnfW) ? 2'd3 : cnf - 2'd1;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Serialises MEM loads/stores and IF fetches onto a byte-wide RAM, one byte per cycle,
// assembling little-endian results and signalling completion with one-cycle pulses.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [MemAddrW-1:0] addr_mem,
  input  logic                wr_mem,
  input  logic [MemDataW-1:0] data_mem,
  input  logic [1:0]          cnf_mem,
  input  logic [RegAddrW-1:0] wd_mem,
  input  logic                wreg_mem,
  input  logic                signed_mem,
  output logic                addr_needed,
  output logic                mem_working,
  output logic                mem_available,
  output logic [InstW-1:0]    data_in,
  output logic [RegAddrW-1:0] wd_back,
  output logic                wreg_back,
  output logic                signed_back,
  output logic [1:0]          cnf_back,
  input  logic                if_req,
  input  logic [MemAddrW-1:0] if_addr,
  input  logic                if_flush,
  output logic [InstW-1:0]    inst_o,
  output logic                inst_valid,
  input  logic [7:0]          mem_din,
  output logic [MemAddrW-1:0] mem_a,
  output logic [7:0]          mem_dout,
  output logic                mem_wr
);

  state_e              state;
  logic [1:0]          cnt_q, cnt_inc, last_q, rd_lane_q, cnf_q;
  logic                issuing_q, rd_pend_q, wreg_q, signed_q;
  logic [MemDataW-1:0] st_data_q;
  logic [InstW-1:0]    asm_q, asm_nx;
  logic [RegAddrW-1:0] wd_q;

  assign cnt_inc     = cnt_q + 2'd1;
  assign addr_needed = !rst && (state == StIdle || state == StMdone || state == StIdone);
  assign mem_working = (state == StMrd) || (state == StMwr);

  // RAM data arrives one cycle after its address; rd_lane_q remembers which lane it belongs to.
  always_comb begin
    asm_nx = asm_q;
    asm_nx[{rd_lane_q, 3'b000} +: 8] = mem_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= StIdle;
      cnt_q         <= 2'd0;
      last_q        <= 2'd0;
      rd_lane_q     <= 2'd0;
      issuing_q     <= 1'b0;
      rd_pend_q     <= 1'b0;
      st_data_q     <= '0;
      asm_q         <= '0;
      wd_q          <= '0;
      wreg_q        <= 1'b0;
      signed_q      <= 1'b0;
      cnf_q         <= CnfNone;
      mem_a         <= '0;
      mem_dout      <= 8'd0;
      mem_wr        <= 1'b0;
      mem_available <= 1'b0;
      data_in       <= '0;
      wd_back       <= '0;
      wreg_back     <= 1'b0;
      signed_back   <= 1'b0;
      cnf_back      <= CnfNone;
      inst_valid    <= 1'b0;
      inst_o        <= '0;
    end else begin
      mem_available <= 1'b0;
      data_in       <= '0;
      wd_back       <= '0;
      wreg_back     <= 1'b0;
      signed_back   <= 1'b0;
      cnf_back      <= CnfNone;
      inst_valid    <= 1'b0;
      inst_o        <= '0;
      unique case (state)
        StMrd, StIrd: begin
          if (state == StIrd && if_flush) begin
            state     <= StIdle;
            issuing_q <= 1'b0;
            rd_pend_q <= 1'b0;
          end else begin
            rd_pend_q <= issuing_q;
            if (issuing_q) begin
              rd_lane_q <= cnt_q;
              if (cnt_q == last_q) begin
                issuing_q <= 1'b0;
              end else begin
                cnt_q <= cnt_inc;
                mem_a <= mem_a + 32'd1;
              end
            end
            if (rd_pend_q) begin
              asm_q <= asm_nx;
              if (rd_lane_q == last_q) begin
                if (state == StIrd) begin
                  state      <= StIdone;
                  inst_valid <= 1'b1;
                  inst_o     <= asm_nx;
                end else begin
                  state         <= StMdone;
                  mem_available <= 1'b1;
                  data_in       <= asm_nx;
                  wd_back       <= wd_q;
                  wreg_back     <= wreg_q;
                  signed_back   <= signed_q;
                  cnf_back      <= cnf_q;
                end
              end
            end
          end
        end
        StMwr: begin
          if (cnt_q == last_q) begin
            state         <= StMdone;
            mem_wr        <= 1'b0;
            mem_available <= 1'b1;
            wd_back       <= wd_q;
            wreg_back     <= wreg_q;
            signed_back   <= signed_q;
            cnf_back      <= cnf_q;
          end else begin
            cnt_q    <= cnt_inc;
            mem_a    <= mem_a + 32'd1;
            mem_dout <= st_data_q[{cnt_inc, 3'b000} +: 8];
          end
        end
        StIdle, StMdone, StIdone: begin
          if (cnf_mem != CnfNone) begin
            mem_a     <= addr_mem;
            cnt_q     <= 2'd0;
            last_q    <= last_idx(cnf_mem);
            cnf_q     <= cnf_mem;
            wd_q      <= wd_mem;
            wreg_q    <= wreg_mem;
            signed_q  <= signed_mem;
            st_data_q <= data_mem;
            asm_q     <= '0;
            rd_pend_q <= 1'b0;
            if (wr_mem) begin
              state     <= StMwr;
              mem_wr    <= 1'b1;
              mem_dout  <= data_mem[7:0];
              issuing_q <= 1'b0;
            end else begin
              state     <= StMrd;
              mem_wr    <= 1'b0;
              issuing_q <= 1'b1;
            end
          end else if (if_req && !if_flush) begin
            state     <= StIrd;
            mem_a     <= if_addr;
            cnt_q     <= 2'd0;
            last_q    <= 2'd3;
            asm_q     <= '0;
            issuing_q <= 1'b1;
            rd_pend_q <= 1'b0;
          end else begin
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomised scoreboard bench for mem_ctrl: a byte RAM model, a reference memory image
// that predicts every completion, and a monitor that checks bus activity and pulses.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr_mem, data_mem, if_addr;
  logic        wr_mem, wreg_mem, signed_mem, if_req, if_flush;
  logic [1:0]  cnf_mem;
  logic [4:0]  wd_mem;
  logic        addr_needed, mem_working, mem_available, wreg_back, signed_back, inst_valid;
  logic [31:0] data_in, inst_o, mem_a;
  logic [4:0]  wd_back;
  logic [1:0]  cnf_back;
  logic [7:0]  mem_din, mem_dout;
  logic        mem_wr;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .addr_mem(addr_mem), .wr_mem(wr_mem), .data_mem(data_mem),
    .cnf_mem(cnf_mem), .wd_mem(wd_mem), .wreg_mem(wreg_mem), .signed_mem(signed_mem),
    .addr_needed(addr_needed), .mem_working(mem_working), .mem_available(mem_available),
    .data_in(data_in), .wd_back(wd_back), .wreg_back(wreg_back), .signed_back(signed_back),
    .cnf_back(cnf_back), .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .inst_o(inst_o), .inst_valid(inst_valid), .mem_din(mem_din), .mem_a(mem_a),
    .mem_dout(mem_dout), .mem_wr(mem_wr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic [4:0]  wd;
    logic        wreg;
    logic        sgn;
    logic [1:0]  cnf;
  } exp_t;
  typedef struct {
    logic [31:0] a;
    logic        wr;
    logic [7:0]  d;
  } bus_t;

  exp_t q_mem[$];
  exp_t q_if[$];
  bus_t bus[int];

  logic [7:0] ram[logic [31:0]];
  logic [7:0] ref_ram[logic [31:0]];

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction
  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : dflt(a);
  endfunction
  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_ram.exists(a) ? ref_ram[a] : dflt(a);
  endfunction

  // Byte-wide synchronous RAM: write on strobe, read data one cycle after the address.
  always @(posedge clk) begin
    if (mem_wr) ram[mem_a] = mem_dout;
    mem_din <= ram_rd(mem_a);
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s @cyc %0d: expected event did not occur", nm, cyc);
  endtask

  // Monitor: bus activity per cycle and completion pulses against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.exists(cyc)) begin
        chk("mem_a", mem_a, bus[cyc].a);
        chk("mem_wr", {31'd0, mem_wr}, {31'd0, bus[cyc].wr});
        if (bus[cyc].wr) chk("mem_dout", {24'd0, mem_dout}, {24'd0, bus[cyc].d});
        bus.delete(cyc);
      end else begin
        chk("mem_wr_idle", {31'd0, mem_wr}, 32'd0);
      end
      if (mem_available) begin
        if (q_mem.size() == 0) begin
          fail("mem_available_unexpected");
        end else begin
          e = q_mem.pop_front();
          chk("mem_done_cycle", cyc, e.due);
          chk("data_in", data_in, e.data);
          chk("wd_back", {27'd0, wd_back}, {27'd0, e.wd});
          chk("wreg_back", {31'd0, wreg_back}, {31'd0, e.wreg});
          chk("signed_back", {31'd0, signed_back}, {31'd0, e.sgn});
          chk("cnf_back", {30'd0, cnf_back}, {30'd0, e.cnf});
        end
      end else begin
        chk("data_in_idle", data_in | {27'd0, wd_back} | {30'd0, cnf_back}, 32'd0);
        if (q_mem.size() != 0 && q_mem[0].due <= cyc) begin
          fail("mem_available_missing");
          void'(q_mem.pop_front());
        end
      end
      if (inst_valid) begin
        if (q_if.size() == 0) begin
          fail("inst_valid_unexpected");
        end else begin
          e = q_if.pop_front();
          chk("inst_done_cycle", cyc, e.due);
          chk("inst_o", inst_o, e.data);
        end
      end else begin
        chk("inst_o_idle", inst_o, 32'd0);
        if (q_if.size() != 0 && q_if[0].due <= cyc) begin
          fail("inst_valid_missing");
          void'(q_if.pop_front());
        end
      end
    end
  end

  // Driver intent and reference timing model.
  logic        m_hold = 1'b0, f_hold = 1'b0, flush = 1'b0;
  logic [31:0] m_addr, m_data, f_addr;
  logic        m_wr, m_wreg, m_sgn;
  logic [1:0]  m_cnf;
  logic [4:0]  m_wd;
  int          next_free = 0;
  int          f_acc = -1;
  int          mw_lo = 1, mw_hi = 0;

  task automatic m_set(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [1:0] c, input logic [4:0] wd, input logic we,
                       input logic s);
    m_hold = 1'b1; m_addr = a; m_wr = w; m_data = d; m_cnf = c; m_wd = wd;
    m_wreg = we; m_sgn = s;
  endtask

  task automatic accept_mem(input int c);
    exp_t e;
    int   n;
    n = (m_cnf == CnfW) ? 4 : int'(m_cnf);
    e.data = 32'd0;
    for (int i = 0; i < n; i++) begin
      if (m_wr) ref_ram[m_addr + 32'(i)] = m_data[8*i +: 8];
      else e.data = e.data | (32'(ref_rd(m_addr + 32'(i))) << (8 * i));
      bus[c + 1 + i] = '{a: m_addr + 32'(i), wr: m_wr, d: m_wr ? m_data[8*i +: 8] : 8'd0};
    end
    e.due = c + (m_wr ? n + 1 : n + 2);
    e.wd = m_wd; e.wreg = m_wreg; e.sgn = m_sgn; e.cnf = m_cnf;
    q_mem.push_back(e);
    next_free = e.due;
    mw_lo = c + 1;
    mw_hi = e.due - 1;
  endtask

  task automatic accept_if(input int c);
    exp_t e;
    e = '{due: c + 6, data: 32'd0, wd: 5'd0, wreg: 1'b0, sgn: 1'b0, cnf: 2'd0};
    for (int i = 0; i < 4; i++) begin
      e.data = e.data | (32'(ref_rd(f_addr + 32'(i))) << (8 * i));
      bus[c + 1 + i] = '{a: f_addr + 32'(i), wr: 1'b0, d: 8'd0};
    end
    q_if.push_back(e);
    next_free = c + 6;
    f_acc = c;
  endtask

  // One cycle: drive at the falling edge, check control outputs, advance the model.
  task automatic step();
    int c;
    c = cyc;
    addr_mem   = m_hold ? m_addr : $urandom;
    wr_mem     = m_hold ? m_wr : 1'($urandom);
    data_mem   = m_hold ? m_data : $urandom;
    cnf_mem    = m_hold ? m_cnf : CnfNone;
    wd_mem     = m_hold ? m_wd : 5'($urandom);
    wreg_mem   = m_hold ? m_wreg : 1'b0;
    signed_mem = m_hold ? m_sgn : 1'b0;
    if_req     = f_hold;
    if_addr    = f_hold ? f_addr : $urandom;
    if_flush   = flush;
    #1;
    chk("addr_needed", {31'd0, addr_needed}, {31'd0, (!rst && c >= next_free)});
    chk("mem_working", {31'd0, mem_working}, {31'd0, (c >= mw_lo && c <= mw_hi)});
    if (!rst) begin
      if (flush && f_acc >= 0 && c > f_acc && c < f_acc + 6) begin
        q_if.delete();
        for (int k = c + 1; k <= f_acc + 4; k++) if (bus.exists(k)) bus.delete(k);
        next_free = c + 1;
        f_acc = -1;
      end
      if (c >= next_free) begin
        if (m_hold) begin
          accept_mem(c);
          m_hold = 1'b0;
        end else if (f_hold && !flush) begin
          accept_if(c);
          f_hold = 1'b0;
        end
      end
      if (flush) f_hold = 1'b0;
    end
    flush = 1'b0;
    @(negedge clk);
  endtask

  task automatic serve(input string nm);
    for (int k = 0; k < 60 && (m_hold || f_hold); k++) step();
    if (m_hold || f_hold) begin
      fail(nm);
      m_hold = 1'b0;
      f_hold = 1'b0;
    end
  endtask

  task automatic wait_free();
    for (int k = 0; k < 40 && cyc < next_free; k++) step();
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_mem_a"}, mem_a, 32'd0);
    chk({nm, "_wr_dout"}, {23'd0, mem_wr, mem_dout}, 32'd0);
    chk({nm, "_flags"}, {26'd0, addr_needed, mem_working, mem_available, inst_valid,
                         wreg_back, signed_back}, 32'd0);
    chk({nm, "_data_in"}, data_in, 32'd0);
    chk({nm, "_inst_o"}, inst_o, 32'd0);
    chk({nm, "_backs"}, {25'd0, wd_back, cnf_back}, 32'd0);
  endtask

  initial begin
    int c0;
    addr_mem = 0; wr_mem = 0; data_mem = 0; cnf_mem = CnfNone; wd_mem = 0;
    wreg_mem = 0; signed_mem = 0; if_req = 0; if_addr = 0; if_flush = 0;
    ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
    ram[32'h300] = 8'hF0;
    ref_ram[32'h100] = 8'h11; ref_ram[32'h101] = 8'h22; ref_ram[32'h102] = 8'h33;
    ref_ram[32'h103] = 8'h44; ref_ram[32'h300] = 8'hF0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    m_set(32'h100, 1'b0, 32'd0, CnfW, 5'd5, 1'b1, 1'b0);
    serve("word_load");
    m_set(32'h200, 1'b1, 32'hDEADBEEF, CnfH, 5'd3, 1'b0, 1'b0);
    serve("half_store");
    m_set(32'h300, 1'b0, 32'd0, CnfB, 5'd7, 1'b1, 1'b1);
    serve("byte_load");
    m_set(32'h200, 1'b0, 32'd0, CnfH, 5'd9, 1'b1, 1'b0);
    f_hold = 1'b1; f_addr = 32'h100;
    serve("mem_and_if");

    wait_free();
    f_hold = 1'b1; f_addr = 32'h0;
    step();
    step();
    step();
    flush = 1'b1;
    step();
    f_hold = 1'b1; f_addr = 32'h104;
    step();

    m_set(32'hFFFF_FFFE, 1'b0, 32'd0, CnfW, 5'd1, 1'b1, 1'b0);
    serve("wrap_load");

    repeat (400) begin
      if (!m_hold && $urandom_range(0, 3) == 0)
        m_set(($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFD : 32'($urandom_range(0, 1023)),
              1'($urandom), $urandom, 2'($urandom_range(1, 3)), 5'($urandom),
              1'($urandom), 1'($urandom));
      if (!f_hold && $urandom_range(0, 2) == 0) begin
        f_hold = 1'b1;
        f_addr = 32'($urandom_range(0, 1023));
      end
      flush = (f_acc >= 0 && cyc > f_acc && cyc < f_acc + 6 && $urandom_range(0, 7) == 0) ||
              (f_hold && $urandom_range(0, 15) == 0);
      step();
    end

    m_hold = 1'b0;
    f_hold = 1'b0;
    wait_free();
    m_set(32'h3F0, 1'b1, $urandom, CnfW, 5'd2, 1'b1, 1'b0);
    c0 = cyc;
    step();
    step();
    rst = 1'b1;
    q_mem.delete();
    for (int k = c0 + 3; k <= c0 + 4; k++) if (bus.exists(k)) bus.delete(k);
    mw_hi = c0 + 2;
    next_free = c0 + 4;
    step();
    check_all_zero("rst_mid_store");
    step();
    rst = 1'b0;
    step();

    m_set(32'h100, 1'b0, 32'd0, CnfW, 5'd4, 1'b0, 1'b1);
    serve("post_reset_load");
    wait_free();
    repeat (3) step();
    chk("mem_queue_drained", q_mem.size(), 32'd0);
    chk("if_queue_drained", q_if.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
